// File: rtl/ucontrol_pkg.sv
// ucontrol_pkg: shared definitions for the ARC-style microsequencer.
//   - sequencer state enum and instruction-class enum
//   - register-select codes, ALU codes, opcode / op3 / condition constants
//   - PSR bit positions ({N,Z,V,C}) and an instruction classifier
package ucontrol_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_PCINC,
    ST_BRANCH,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_ALU,
    K_ALUCC,
    K_JMPL,
    K_BRANCH,
    K_ILLEGAL
  } kind_t;

  // Register-select codes (R0..R3 are 0..3)
  localparam int unsigned REG_RS   = 4;
  localparam int unsigned REG_PC   = 5;
  localparam int unsigned REG_IR   = 6;
  localparam int unsigned REG_NONE = 15;

  // ALU codes driven by the sequencer itself
  localparam int unsigned ALU_PASSA = 4'hE;
  localparam int unsigned ALU_INC4  = 4'hF;

  // Major opcodes and op3 values
  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_ALU    = 2'b10;
  localparam logic [1:0] OP_MEMJ   = 2'b11;
  localparam logic [5:0] OP3_JMPL  = 6'b111000;

  // Branch conditions (rd[3:0])
  localparam logic [3:0] COND_BE   = 4'b0001;
  localparam logic [3:0] COND_BCS  = 4'b0101;
  localparam logic [3:0] COND_BNEG = 4'b0110;
  localparam logic [3:0] COND_BVS  = 4'b0111;
  localparam logic [3:0] COND_BA   = 4'b1000;

  // PSR bit positions inside {N,Z,V,C}
  localparam int PSR_N = 3;
  localparam int PSR_Z = 2;
  localparam int PSR_V = 1;
  localparam int PSR_C = 0;

  // Only R0..R3, RS and PC may be named by an instruction field.
  function automatic logic reg_ok(input logic [4:0] r);
    return (r <= 5'd5);
  endfunction

  function automatic kind_t classify(input logic [31:0] ir);
    kind_t k;
    k = K_ILLEGAL;
    case (ir[31:30])
      OP_ALU:
        if (reg_ok(ir[29:25]) && reg_ok(ir[18:14]) && reg_ok(ir[4:0]))
          k = ir[23] ? K_ALUCC : K_ALU;
      OP_MEMJ:
        if ((ir[24:19] == OP3_JMPL) && reg_ok(ir[18:14]))
          k = K_JMPL;
      OP_BRANCH:
        // rs1 supplies the target in the BRANCH step, so it must be valid too.
        if (reg_ok(ir[18:14]))
          k = K_BRANCH;
      default: k = K_ILLEGAL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ucontrol_cond_eval.sv
// ucontrol_cond_eval: combinational branch-condition evaluator.
//   i_psr   [3:0] latched PSR {N,Z,V,C}, active-high
//   i_cond  [3:0] condition field (rd[3:0] of a branch)
//   o_taken       1 when the branch is taken; unsupported codes are never taken
module ucontrol_cond_eval
  import ucontrol_pkg::*;
(
  input  logic [3:0] i_psr,
  input  logic [3:0] i_cond,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_BE:   o_taken = i_psr[PSR_Z];
      COND_BCS:  o_taken = i_psr[PSR_C];
      COND_BNEG: o_taken = i_psr[PSR_N];
      COND_BVS:  o_taken = i_psr[PSR_V];
      COND_BA:   o_taken = 1'b1;
      default:   o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ucontrol_sequencer.sv
// ucontrol_sequencer: microsequencer for the ARC-style datapath.
// Fetches 32-bit instructions over a req/ack handshake into an internal IR,
// then sequences FETCH -> EXEC -> PCINC/BRANCH, driving register selects,
// ALU op and clear select. All outputs are registered per state.
//
// Ports:
//   uCONTROL_CLOCK_50                 clock, rising edge
//   uCONTROL_RESET_InLow              synchronous active-low reset
//   uCONTROL_run_InHigh               start / continue execution
//   uCONTROL_imem_data_InBUS          instruction word, valid with ack
//   uCONTROL_imem_ack_InHigh          memory acknowledge
//   uCONTROL_{overflow,carry,negative,zero}_InLow  datapath flags, active-low
//   uCONTROL_imem_req_OutHigh         fetch request (address = PC on bus A)
//   uCONTROL_BUS_CONTROL_A/B/C        register-select codes
//   uCONTROL_BUS_SELECTOR_A/B/C       constant 0
//   uCONTROL_aluselection_OutBUS      ALU op
//   uCONTROL_decoderclearselection_OutBUS  register clear select
//   uCONTROL_psr_OutBUS               latched {N,Z,V,C}
//   uCONTROL_illegal_OutHigh          one-cycle illegal-instruction pulse
//   uCONTROL_fault_OutHigh            sticky fetch-timeout fault
//
// Optional feature: define UCONTROL_FETCH_TIMEOUT_EN to enable the fetch
// watchdog (TIMEOUT_CYCLES FETCH cycles without ack -> HALT with fault).
module ucontrol_sequencer
  import ucontrol_pkg::*;
#(
  parameter int DATAWIDTH_BUS               = 32,
  parameter int DATAWIDTH_DECODER_SELECTION = 4,
  parameter int DATAWIDTH_ALU_SELECTION     = 4,
  parameter int DATA_BUS_CONTROL            = 6,
  parameter int TIMEOUT_CYCLES              = 16
) (
  input  logic                                   uCONTROL_CLOCK_50,
  input  logic                                   uCONTROL_RESET_InLow,
  input  logic                                   uCONTROL_run_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]               uCONTROL_imem_data_InBUS,
  input  logic                                   uCONTROL_imem_ack_InHigh,
  input  logic                                   uCONTROL_overflow_InLow,
  input  logic                                   uCONTROL_carry_InLow,
  input  logic                                   uCONTROL_negative_InLow,
  input  logic                                   uCONTROL_zero_InLow,
  output logic                                   uCONTROL_imem_req_OutHigh,
  output logic [DATA_BUS_CONTROL-1:0]            uCONTROL_BUS_CONTROL_A,
  output logic [DATA_BUS_CONTROL-1:0]            uCONTROL_BUS_CONTROL_B,
  output logic [DATA_BUS_CONTROL-1:0]            uCONTROL_BUS_CONTROL_C,
  output logic                                   uCONTROL_BUS_SELECTOR_A,
  output logic                                   uCONTROL_BUS_SELECTOR_B,
  output logic                                   uCONTROL_BUS_SELECTOR_C,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]     uCONTROL_aluselection_OutBUS,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] uCONTROL_decoderclearselection_OutBUS,
  output logic [3:0]                             uCONTROL_psr_OutBUS,
  output logic                                   uCONTROL_illegal_OutHigh,
  output logic                                   uCONTROL_fault_OutHigh
);

  localparam logic [DATA_BUS_CONTROL-1:0] C_PC   = DATA_BUS_CONTROL'(REG_PC);
  localparam logic [DATA_BUS_CONTROL-1:0] C_NONE = DATA_BUS_CONTROL'(REG_NONE);
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] C_PASSA = DATAWIDTH_ALU_SELECTION'(ALU_PASSA);
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] C_INC4  = DATAWIDTH_ALU_SELECTION'(ALU_INC4);
  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] CLR_PC   = DATAWIDTH_DECODER_SELECTION'(REG_PC);
  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] CLR_NONE = DATAWIDTH_DECODER_SELECTION'(REG_NONE);

  state_t r_state, w_state_next;
  logic [DATAWIDTH_BUS-1:0] r_ir, w_ir_next;
  kind_t  w_kind_cur, w_kind_next;
  logic   w_taken;
  logic   w_tmo_hit;
  logic [3:0] r_psr;

  logic [DATA_BUS_CONTROL-1:0]            r_bus_a, r_bus_b, r_bus_c;
  logic [DATA_BUS_CONTROL-1:0]            w_bus_a, w_bus_b, w_bus_c;
  logic [DATAWIDTH_ALU_SELECTION-1:0]     r_alu, w_alu;
  logic [DATAWIDTH_DECODER_SELECTION-1:0] r_clr, w_clr;
  logic r_req, w_req, r_illegal, w_illegal, r_fault, w_fault;

  // Bits [13:5] of the instruction word carry no field this sequencer uses.
  logic w_unused_ir;
  assign w_unused_ir = ^r_ir[13:5];

  // The IR loads on the edge that samples ack; outputs for EXEC are decoded
  // from the incoming word so they are valid from the first EXEC cycle.
  assign w_ir_next   = ((r_state == ST_FETCH) && uCONTROL_imem_ack_InHigh)
                       ? uCONTROL_imem_data_InBUS : r_ir;
  assign w_kind_cur  = classify(r_ir[31:0]);
  assign w_kind_next = classify(w_ir_next[31:0]);

  ucontrol_cond_eval u_cond_eval (
    .i_psr   (r_psr),
    .i_cond  (r_ir[28:25]),
    .o_taken (w_taken)
  );

`ifdef UCONTROL_FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] r_tmo;

  // Counts ack-less FETCH cycles; held at zero outside FETCH so every entry
  // into FETCH starts a fresh window.
  always_ff @(posedge uCONTROL_CLOCK_50) begin
    if (!uCONTROL_RESET_InLow || (r_state != ST_FETCH) || uCONTROL_imem_ack_InHigh)
      r_tmo <= '0;
    else
      r_tmo <= r_tmo + TMO_W'(1);
  end

  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_tmo_hit = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (uCONTROL_run_InHigh) w_state_next = ST_INIT;
      ST_INIT:   w_state_next = ST_FETCH;
      ST_FETCH: begin
        if (uCONTROL_imem_ack_InHigh) w_state_next = ST_EXEC;
        else if (w_tmo_hit)           w_state_next = ST_HALT;
      end
      ST_EXEC: begin
        case (w_kind_cur)
          K_JMPL:   w_state_next = ST_BRANCH;
          K_BRANCH: w_state_next = w_taken ? ST_BRANCH : ST_PCINC;
          default:  w_state_next = ST_PCINC;
        endcase
      end
      ST_PCINC, ST_BRANCH:
        w_state_next = uCONTROL_run_InHigh ? ST_FETCH : ST_IDLE;
      ST_HALT:   w_state_next = ST_HALT;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Output decode for the state being entered, registered below
  always_comb begin
    w_bus_a   = '0;
    w_bus_b   = '0;
    w_bus_c   = C_NONE;
    w_alu     = C_PASSA;
    w_clr     = CLR_NONE;
    w_req     = 1'b0;
    w_illegal = 1'b0;
    w_fault   = r_fault;
    case (w_state_next)
      ST_INIT:  w_clr = CLR_PC;
      ST_FETCH: begin
        w_bus_a = C_PC;
        w_req   = 1'b1;
      end
      ST_EXEC: begin
        if ((w_kind_next == K_ALU) || (w_kind_next == K_ALUCC)) begin
          w_bus_a = DATA_BUS_CONTROL'(w_ir_next[18:14]);
          w_bus_b = DATA_BUS_CONTROL'(w_ir_next[4:0]);
          w_bus_c = DATA_BUS_CONTROL'(w_ir_next[29:25]);
          w_alu   = DATAWIDTH_ALU_SELECTION'(w_ir_next[22:19]);
        end else if (w_kind_next == K_ILLEGAL) begin
          w_illegal = 1'b1;
        end
      end
      ST_PCINC: begin
        w_bus_a = C_PC;
        w_alu   = C_INC4;
        w_bus_c = C_PC;
      end
      ST_BRANCH: begin
        w_bus_a = DATA_BUS_CONTROL'(w_ir_next[18:14]);
        w_bus_c = C_PC;
      end
      ST_HALT:  w_fault = 1'b1;
      default:  ;
    endcase
  end

  // State / output register stage
  always_ff @(posedge uCONTROL_CLOCK_50) begin
    if (!uCONTROL_RESET_InLow) begin
      r_state   <= ST_IDLE;
      r_bus_a   <= '0;
      r_bus_b   <= '0;
      r_bus_c   <= C_NONE;
      r_alu     <= C_PASSA;
      r_clr     <= CLR_NONE;
      r_req     <= 1'b0;
      r_illegal <= 1'b0;
      r_fault   <= 1'b0;
      r_psr     <= 4'b0000;
    end else begin
      r_state   <= w_state_next;
      r_bus_a   <= w_bus_a;
      r_bus_b   <= w_bus_b;
      r_bus_c   <= w_bus_c;
      r_alu     <= w_alu;
      r_clr     <= w_clr;
      r_req     <= w_req;
      r_illegal <= w_illegal;
      r_fault   <= w_fault;
      if ((r_state == ST_EXEC) && (w_kind_cur == K_ALUCC))
        r_psr <= {~uCONTROL_negative_InLow, ~uCONTROL_zero_InLow,
                  ~uCONTROL_overflow_InLow, ~uCONTROL_carry_InLow};
    end
  end

  // Instruction register: pure data, contents irrelevant until first fetch
  always_ff @(posedge uCONTROL_CLOCK_50) begin
    r_ir <= w_ir_next;
  end

  assign uCONTROL_imem_req_OutHigh             = r_req;
  assign uCONTROL_BUS_CONTROL_A                = r_bus_a;
  assign uCONTROL_BUS_CONTROL_B                = r_bus_b;
  assign uCONTROL_BUS_CONTROL_C                = r_bus_c;
  assign uCONTROL_BUS_SELECTOR_A               = 1'b0;
  assign uCONTROL_BUS_SELECTOR_B               = 1'b0;
  assign uCONTROL_BUS_SELECTOR_C               = 1'b0;
  assign uCONTROL_aluselection_OutBUS          = r_alu;
  assign uCONTROL_decoderclearselection_OutBUS = r_clr;
  assign uCONTROL_psr_OutBUS                   = r_psr;
  assign uCONTROL_illegal_OutHigh              = r_illegal;
  assign uCONTROL_fault_OutHigh                = r_fault;

endmodule
